// File: rtl/reg_addr_sequencer_if.sv
// Handshake bundle between the control unit, the address sequencer and the
// register-file port select. The master side issues operations and acts as the
// downstream consumer (ready); the slave side is the sequencer itself.
interface reg_addr_sequencer_if #(
  parameter int AW  = 4,
  parameter int IRW = 32
);
  logic           start;
  logic [1:0]     mode;
  logic [IRW-1:0] ir;
  logic [AW-1:0]  px;
  logic           ready;
  logic           busy;
  logic           out_valid;
  logic [AW-1:0]  out_addr;
  logic           out_last;
  logic           done;
  logic [AW:0]    out_count;

  modport master (
    output start, mode, ir, px, ready,
    input  busy, out_valid, out_addr, out_last, done, out_count
  );

  modport slave (
    input  start, mode, ir, px, ready,
    output busy, out_valid, out_addr, out_last, done, out_count
  );
endinterface

// File: rtl/reg_addr_sequencer.sv
// Register-file address source for the control unit. Single-address modes
// emit one beat (IR field, IR field plus offset, or a fixed PC index); list
// mode walks the IR register bitmap lowest index first, one address per
// accepted beat, and finishes with a one-cycle done pulse carrying the beat
// count.
module reg_addr_sequencer #(
  parameter int            AW       = 4,
  parameter int            IRW      = 32,
  parameter logic [AW-1:0] CONST_PC = AW'(15)
) (
  input logic                clk,
  input logic                reset,
  reg_addr_sequencer_if.slave bus
);

  localparam int NREG = 1 << AW;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] MODE_FIELD  = 2'd0;
  localparam logic [1:0] MODE_OFFSET = 2'd1;
  localparam logic [1:0] MODE_CONST  = 2'd2;
  localparam logic [1:0] MODE_LIST   = 2'd3;

  state_t          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            last_q, last_d;
  logic [NREG-1:0] list_q, list_d;
  logic [AW:0]     count_q, count_d;
  logic [NREG-1:0] remaining;
  logic            accept;

  // Index of the lowest set bit; zero when the vector is empty.
  function automatic logic [AW-1:0] lowest_index(input logic [NREG-1:0] v);
    logic [AW-1:0] idx;
    idx = '0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (v[i]) idx = AW'(i);
    end
    return idx;
  endfunction

  // True when exactly one bit of the vector is set.
  function automatic logic single_bit(input logic [NREG-1:0] v);
    return (v != '0) && ((v & (v - NREG'(1))) == '0);
  endfunction

  assign accept = (state_q == EMIT) && bus.ready;

  // Next-state and next-datapath logic: capture on start, advance on accept.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    last_d    = last_q;
    list_d    = list_q;
    count_d   = count_q;
    remaining = list_q & ~(NREG'(1) << addr_q);

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          count_d = '0;
          list_d  = '0;
          last_d  = 1'b1;
          state_d = EMIT;
          case (bus.mode)
            MODE_FIELD:  addr_d = bus.ir[16 +: AW];
            MODE_OFFSET: addr_d = bus.ir[12 +: AW] + bus.px;
            MODE_CONST:  addr_d = CONST_PC;
            MODE_LIST: begin
              list_d = bus.ir[NREG-1:0];
              if (bus.ir[NREG-1:0] == '0) begin
                state_d = DONE;
                last_d  = 1'b0;
              end else begin
                addr_d = lowest_index(bus.ir[NREG-1:0]);
                last_d = single_bit(bus.ir[NREG-1:0]);
              end
            end
            default: addr_d = addr_q;
          endcase
        end
      end

      EMIT: begin
        if (accept) begin
          count_d = count_q + (AW+1)'(1);
          if (last_q) begin
            list_d  = '0;
            last_d  = 1'b0;
            state_d = DONE;
          end else begin
            list_d = remaining;
            addr_d = lowest_index(remaining);
            last_d = single_bit(remaining);
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      last_q  <= 1'b0;
      list_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      last_q  <= last_d;
      list_q  <= list_d;
      count_q <= count_d;
    end
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.out_valid = (state_q == EMIT);
  assign bus.out_addr  = addr_q;
  assign bus.out_last  = last_q && (state_q == EMIT);
  assign bus.done      = (state_q == DONE);
  assign bus.out_count = count_q;

  // Only a few instruction fields are decoded; the rest are deliberately ignored.
  logic unused_ir_bits;
  assign unused_ir_bits = ^bus.ir;

endmodule

// File: tb/tb_reg_addr_sequencer.sv
// Self-checking bench for reg_addr_sequencer: directed cases followed by
// random operations, each compared against a list of expected addresses
// derived straight from the mode rules.
module tb_reg_addr_sequencer;

  localparam int AW  = 4;
  localparam int IRW = 32;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  reg_addr_sequencer_if #(.AW(AW), .IRW(IRW)) bus ();

  reg_addr_sequencer #(.AW(AW), .IRW(IRW), .CONST_PC(4'd15)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected beat list computed from the mode rules alone.
  task automatic expected_beats(input logic [1:0] mode, input logic [31:0] ir,
                                input logic [3:0] px, output int q[$]);
    q = {};
    case (mode)
      2'd0: q.push_back(int'(ir[19:16]));
      2'd1: q.push_back((int'(ir[15:12]) + int'(px)) % 16);
      2'd2: q.push_back(15);
      default: for (int i = 0; i < 16; i++) if (ir[i]) q.push_back(i);
    endcase
  endtask

  // One full operation: start, walk every beat with the chosen ready policy,
  // then check the done pulse and the return to idle.
  task automatic apply_stimulus(input logic [1:0] mode, input logic [31:0] ir,
                                input logic [3:0] px, input bit rand_ready,
                                input int first_stall, input bit poke_start);
    int q[$];
    int idx;
    int cycles;
    int stalls;
    expected_beats(mode, ir, px, q);
    @(negedge clk);
    bus.start = 1'b1;
    bus.mode  = mode;
    bus.ir    = ir;
    bus.px    = px;
    bus.ready = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    idx = 0;
    cycles = 0;
    stalls = 0;
    while (idx < q.size() && cycles < 200) begin
      check_output("busy", 32'(bus.busy), 32'd1);
      check_output("valid", 32'(bus.out_valid), 32'd1);
      check_output("addr", 32'(bus.out_addr), 32'(q[idx]));
      check_output("last", 32'(bus.out_last), 32'(idx == q.size() - 1));
      check_output("done_early", 32'(bus.done), 32'd0);
      bus.mode  = 2'($urandom);
      bus.ir    = $urandom;
      bus.px    = 4'($urandom);
      bus.start = poke_start ? 1'($urandom) : 1'b0;
      if (idx == 0 && stalls < first_stall) begin
        bus.ready = 1'b0;
        stalls++;
      end else begin
        bus.ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      @(negedge clk);
      if (bus.ready) idx++;
      cycles++;
    end
    check_output("beats_done", 32'(idx), 32'(q.size()));
    check_output("done", 32'(bus.done), 32'd1);
    check_output("done_valid", 32'(bus.out_valid), 32'd0);
    check_output("done_busy", 32'(bus.busy), 32'd1);
    check_output("count", 32'(bus.out_count), 32'(q.size()));
    bus.ready = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check_output("done_pulse_end", 32'(bus.done), 32'd0);
    check_output("idle_busy", 32'(bus.busy), 32'd0);
    check_output("idle_valid", 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    int n;
    logic [1:0] m;
    logic [31:0] w;
    checks   = 0;
    failures = 0;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.mode  = 2'd0;
    bus.ir    = '0;
    bus.px    = '0;
    bus.ready = 1'b0;
    repeat (2) @(negedge clk);
    check_output("rst_busy", 32'(bus.busy), 32'd0);
    check_output("rst_valid", 32'(bus.out_valid), 32'd0);
    check_output("rst_addr", 32'(bus.out_addr), 32'd0);
    check_output("rst_last", 32'(bus.out_last), 32'd0);
    check_output("rst_done", 32'(bus.done), 32'd0);
    check_output("rst_count", 32'(bus.out_count), 32'd0);
    reset = 1'b0;

    $display("[TB] directed cases");
    apply_stimulus(2'd0, 32'h000A_0000, 4'd0, 1'b0, 0, 1'b0);
    apply_stimulus(2'd1, 32'h0000_E000, 4'd3, 1'b0, 0, 1'b0);
    apply_stimulus(2'd2, 32'hFFFF_FFFF, 4'd7, 1'b0, 0, 1'b0);
    apply_stimulus(2'd3, 32'h0000_8025, 4'd0, 1'b0, 0, 1'b0);
    apply_stimulus(2'd3, 32'h0000_0006, 4'd0, 1'b0, 3, 1'b1);
    apply_stimulus(2'd3, 32'hFFFF_0000, 4'd0, 1'b0, 0, 1'b0);
    apply_stimulus(2'd3, 32'h0000_8000, 4'd0, 1'b1, 2, 1'b0);

    $display("[TB] reset in the middle of a full list");
    @(negedge clk);
    bus.start = 1'b1;
    bus.mode  = 2'd3;
    bus.ir    = 32'h0000_FFFF;
    bus.ready = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    check_output("pre_rst_addr", 32'(bus.out_addr), 32'd5);
    #2 reset = 1'b1;
    #1;
    check_output("arst_busy", 32'(bus.busy), 32'd0);
    check_output("arst_valid", 32'(bus.out_valid), 32'd0);
    check_output("arst_addr", 32'(bus.out_addr), 32'd0);
    check_output("arst_done", 32'(bus.done), 32'd0);
    check_output("arst_count", 32'(bus.out_count), 32'd0);
    @(negedge clk);
    check_output("arst_no_done", 32'(bus.done), 32'd0);
    reset = 1'b0;
    bus.ready = 1'b0;
    apply_stimulus(2'd3, 32'h0000_0813, 4'd0, 1'b1, 1, 1'b1);

    $display("[TB] random operations");
    for (int k = 0; k < 40; k++) begin
      m = 2'($urandom);
      w = $urandom;
      n = $urandom_range(0, 3);
      if (m == 2'd3 && n == 0) w[15:0] = 16'h0000;
      apply_stimulus(m, w, 4'($urandom), 1'b1, $urandom_range(0, 2), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
